// File: rtl/bus_if_pkg.sv
// rtl/bus_if_pkg.sv - shared state encoding and constants for the CPU bus interface
package bus_if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } bus_if_state_e;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DEF_ADDR_W      = 30;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SLAVE_IDX_W = 3;

endpackage

// File: rtl/bus_timeout_cnt.sv
// rtl/bus_timeout_cnt.sv - ACCESS-cycle counter flagging the last permitted wait cycle
module bus_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The counter reads N-1 in the N-th enabled cycle, so this fires in cycle TIMEOUT.
    assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - MEM-stage bus interface routing accesses to the SPM or the shared bus
module bus_master_if
    import bus_if_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SLAVE_IDX_W = DEF_SLAVE_IDX_W,
    parameter int SPM_INDEX   = 1,
    parameter int POSTED_WR   = 1,
    parameter int TIMEOUT     = 255,
    localparam int BE_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    output logic              err,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [BE_W-1:0]   spm_be,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    input  logic              bus_grnt_,
    output logic              bus_req_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [BE_W-1:0]   bus_be,
    output logic [DATA_W-1:0] bus_wr_data
);

    bus_if_state_e    r_state;
    bus_if_state_e    w_next;
    logic             r_posted;
    logic [DATA_W-1:0] r_rd_buf;
    logic             r_bus_req_;
    logic             r_bus_as_;
    logic             r_bus_rw;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [BE_W-1:0]  r_bus_be;
    logic [DATA_W-1:0] r_bus_wr_data;

    logic [SLAVE_IDX_W-1:0] w_sidx;
    logic w_valid, w_spm_hit, w_ext, w_rdy, w_expired, w_timeout, w_done;

    assign w_sidx    = addr[ADDR_W-1 -: SLAVE_IDX_W];
    assign w_valid   = (as_ == ENABLE_) && !flush;
    assign w_spm_hit = w_valid && (w_sidx == SLAVE_IDX_W'(SPM_INDEX));
    assign w_ext     = w_valid && !w_spm_hit;
    assign w_rdy     = (r_state == ACCESS) && (bus_rdy_ == ENABLE_);
    assign w_timeout = w_expired && (bus_rdy_ == DISABLE_);
    assign w_done    = w_rdy || w_timeout;

    bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (r_state != ACCESS),
        .i_en      (r_state == ACCESS),
        .o_expired (w_expired)
    );

    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_be      = be;
    assign spm_wr_data = wr_data;

    assign bus_req_    = r_bus_req_;
    assign bus_as_     = r_bus_as_;
    assign bus_rw      = r_bus_rw;
    assign bus_addr    = r_bus_addr;
    assign bus_be      = r_bus_be;
    assign bus_wr_data = r_bus_wr_data;

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        err     = 1'b0;
        rd_data = '0;
        spm_as_ = DISABLE_;
        unique case (r_state)
            IDLE: begin
                if (w_spm_hit) begin
                    spm_as_ = stall ? DISABLE_ : ENABLE_;
                    if (rw == READ) rd_data = spm_rd_data;
                end else if (w_ext) begin
                    w_next = REQ;
                    busy   = !((rw == WRITE) && (POSTED_WR != 0));
                end
            end
            REQ: begin
                busy = r_posted ? w_valid : 1'b1;
                if (bus_grnt_ == ENABLE_) w_next = ACCESS;
            end
            ACCESS: begin
                // A posted drain only holds the CPU if it is presenting a new access.
                busy = r_posted ? w_valid : !w_done;
                if (w_done) begin
                    err    = w_timeout;
                    w_next = (stall && !r_posted) ? STALL : IDLE;
                    if (w_rdy && (r_bus_rw == READ)) rd_data = bus_rd_data;
                end
            end
            STALL: begin
                if (rw == READ) rd_data = r_rd_buf;
                if (!stall) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_posted      <= 1'b0;
            r_rd_buf      <= '0;
            r_bus_req_    <= DISABLE_;
            r_bus_as_     <= DISABLE_;
            r_bus_rw      <= READ;
            r_bus_addr    <= '0;
            r_bus_be      <= '0;
            r_bus_wr_data <= '0;
        end else begin
            r_state   <= w_next;
            r_bus_as_ <= ((r_state == REQ) && (bus_grnt_ == ENABLE_)) ? ENABLE_ : DISABLE_;
            if ((r_state == IDLE) && w_ext) begin
                r_bus_req_    <= ENABLE_;
                r_bus_addr    <= addr;
                r_bus_rw      <= rw;
                r_bus_be      <= be;
                r_bus_wr_data <= wr_data;
                r_posted      <= (rw == WRITE) && (POSTED_WR != 0);
            end
            if (w_done) begin
                r_bus_req_    <= DISABLE_;
                r_bus_addr    <= '0;
                r_bus_rw      <= READ;
                r_bus_be      <= '0;
                r_bus_wr_data <= '0;
                r_posted      <= 1'b0;
                if (w_timeout) begin
                    r_rd_buf <= '0;
                end else if (r_bus_rw == READ) begin
                    r_rd_buf <= bus_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - scoreboard bench for bus_master_if with a scripted bus slave
module tb_bus_master_if;
    import bus_if_pkg::*;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam logic [ADDR_W-1:0] SPM_ADDR = 30'h0800_0004;
    localparam logic [ADDR_W-1:0] EXT_A    = 30'h1000_0020;
    localparam logic [ADDR_W-1:0] EXT_B    = 30'h1800_0044;

    logic clk = 1'b0;
    logic reset, stall, flush, as_, rw;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wr_data, spm_rd_data, bus_rd_data;
    logic bus_rdy_, bus_grnt_;
    logic busy, err, spm_as_, spm_rw, bus_req_, bus_as_, bus_rw;
    logic [DATA_W-1:0] rd_data, spm_wr_data, bus_wr_data;
    logic [ADDR_W-1:0] spm_addr, bus_addr;
    logic [BE_W-1:0]   spm_be, bus_be;

    int n_vec = 0;
    int n_err = 0;
    int gnt_wait = 0;
    int rdy_wait = 0;
    bit rdy_never = 1'b0;
    logic [DATA_W-1:0] slave_data = '0;
    logic [DATA_W-1:0] exp_q[$];
    int cyc, as_lows, errs;

    always #5 clk = ~clk;

    bus_master_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLAVE_IDX_W(3),
        .SPM_INDEX(1), .POSTED_WR(1), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .busy(busy), .err(err), .addr(addr), .as_(as_), .rw(rw), .be(be),
        .wr_data(wr_data), .rd_data(rd_data), .spm_rd_data(spm_rd_data),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_be(spm_be),
        .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
        .bus_grnt_(bus_grnt_), .bus_req_(bus_req_), .bus_addr(bus_addr),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_be(bus_be), .bus_wr_data(bus_wr_data)
    );

    // Slave: grants after gnt_wait REQ cycles, readies after rdy_wait ACCESS cycles.
    initial begin : slave
        int s_phase;
        int s_cnt;
        bit s_granted;
        s_phase = 0; s_cnt = 0; s_granted = 1'b0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'hA5A5_A5A5;
        forever begin
            @(posedge clk); #1;
            bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'hA5A5_A5A5;
            if (bus_req_ !== 1'b0) begin
                s_phase = 0; s_granted = 1'b0;
            end else begin
                if (s_phase == 0) begin
                    s_phase = 1; s_cnt = 0;
                end else if (s_phase == 1 && s_granted) begin
                    s_phase = 2; s_cnt = 0;
                end else begin
                    s_cnt++;
                end
                s_granted = 1'b0;
                if (s_phase == 1 && s_cnt >= gnt_wait) begin
                    bus_grnt_ = 1'b0; s_granted = 1'b1;
                end
                if (s_phase == 2 && s_cnt >= rdy_wait && !rdy_never) begin
                    bus_rdy_ = 1'b0; bus_rd_data = slave_data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [DATA_W-1:0] e;
        chk({tag, "_pending"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, 64'(rd_data), 64'(e));
        end
    endtask

    task automatic wait_done(input string tag, input int max_cyc,
                             output int n_cyc, output int n_as, output int n_err_p);
        n_cyc = 0; n_as = 0; n_err_p = 0;
        forever begin
            @(negedge clk);
            if (bus_as_ == ENABLE_) n_as++;
            if (err) n_err_p++;
            if (!busy) break;
            if (n_cyc >= max_cyc) begin
                chk({tag, "_hang"}, 64'(busy), 64'd0);
                break;
            end
            tick();
            n_cyc++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_rd"}, 64'(rd_data), 64'd0);
        chk({tag, "_spm_as"}, 64'(spm_as_), 64'd1);
        chk({tag, "_req_as_rw"}, 64'({bus_req_, bus_as_, bus_rw}), 64'b111);
        chk({tag, "_bus_regs"}, 64'({bus_addr, bus_be, bus_wr_data}), 64'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = READ;
        addr = '0; be = '0; wr_data = '0; spm_rd_data = '0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // SPM read, zero wait states
        tick();
        addr = SPM_ADDR; as_ = 1'b0; rw = READ; be = 4'hF; spm_rd_data = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        chk("spm_as", 64'(spm_as_), 64'd0);
        chk("spm_busy", 64'(busy), 64'd0);
        chk("spm_addr", 64'(spm_addr), 64'(SPM_ADDR));
        sb_check("spm_rd");
        tick();
        as_ = 1'b1;
        @(negedge clk);
        chk("spm_no_req", 64'(bus_req_), 64'd1);

        // External read: grant in 2nd REQ cycle, ready in 2nd ACCESS cycle
        tick();
        gnt_wait = 1; rdy_wait = 1; slave_data = 32'hCAFE_0001;
        addr = EXT_A; as_ = 1'b0; rw = READ;
        exp_q.push_back(32'hCAFE_0001);
        wait_done("ext_rd", 20, cyc, as_lows, errs);
        chk("ext_rd_busy_cycles", 64'(cyc), 64'd4);
        chk("ext_rd_as_pulses", 64'(as_lows), 64'd1);
        chk("ext_rd_addr", 64'(bus_addr), 64'(EXT_A));
        sb_check("ext_rd");
        tick();
        as_ = 1'b1;
        chk("ext_rd_release", 64'({bus_req_, bus_rw, bus_addr}), 64'({1'b1, 1'b1, 30'd0}));

        // Read completing under stall holds rd_buf until stall drops
        tick();
        gnt_wait = 0; rdy_wait = 0; slave_data = 32'h1234_5678;
        addr = EXT_B; as_ = 1'b0; rw = READ; stall = 1'b1;
        exp_q.push_back(32'h1234_5678);
        wait_done("stl_rd", 20, cyc, as_lows, errs);
        chk("stl_rd_cycles", 64'(cyc), 64'd2);
        sb_check("stl_rd");
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_q.push_back(32'h1234_5678);
            @(negedge clk);
            chk("stl_hold_busy", 64'(busy), 64'd0);
            sb_check("stl_hold");
        end
        tick();
        stall = 1'b0;
        exp_q.push_back(32'h1234_5678);
        @(negedge clk);
        sb_check("stl_drop");
        tick();
        as_ = 1'b1;
        @(negedge clk);
        chk("stl_idle_rd", 64'(rd_data), 64'd0);

        // Posted write followed immediately by an external read
        tick();
        gnt_wait = 1; rdy_wait = 1; slave_data = 32'h0BAD_F00D;
        addr = EXT_A; as_ = 1'b0; rw = WRITE; be = 4'b0011; wr_data = 32'h55AA_1234;
        @(negedge clk);
        chk("pw_busy", 64'(busy), 64'd0);
        tick();
        chk("pw_bus_regs", 64'({bus_rw, bus_be, bus_wr_data}), 64'({1'b0, 4'b0011, 32'h55AA_1234}));
        addr = EXT_B; rw = READ; be = 4'hF; wr_data = '0;
        exp_q.push_back(32'h0BAD_F00D);
        wait_done("pw_rd", 30, cyc, as_lows, errs);
        chk("pw_rd_busy_cycles", 64'(cyc), 64'd8);
        chk("pw_rd_as_pulses", 64'(as_lows), 64'd2);
        chk("pw_rd_addr", 64'(bus_addr), 64'(EXT_B));
        sb_check("pw_rd");
        tick();
        as_ = 1'b1;

        // Timeout with stall: err in 4th ACCESS cycle, rd_buf cleared
        tick();
        gnt_wait = 0; rdy_never = 1'b1;
        addr = EXT_A; as_ = 1'b0; rw = READ; stall = 1'b1;
        exp_q.push_back(32'h0);
        wait_done("to_rd", 20, cyc, as_lows, errs);
        chk("to_cycles", 64'(cyc), 64'd5);
        chk("to_err_now", 64'(err), 64'd1);
        chk("to_err_pulses", 64'(errs), 64'd1);
        sb_check("to_rd");
        tick();
        chk("to_req_released", 64'(bus_req_), 64'd1);
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("to_err_cleared", 64'(err), 64'd0);
        sb_check("to_rd_buf");
        tick();
        stall = 1'b0; as_ = 1'b1; rdy_never = 1'b0;

        // Ready in the final permitted cycle wins over the timeout
        tick();
        gnt_wait = 0; rdy_wait = 3; slave_data = 32'h7777_0003;
        addr = EXT_B; as_ = 1'b0; rw = READ;
        exp_q.push_back(32'h7777_0003);
        wait_done("late_rdy", 20, cyc, as_lows, errs);
        chk("late_rdy_cycles", 64'(cyc), 64'd5);
        chk("late_rdy_errs", 64'(errs), 64'd0);
        sb_check("late_rdy");
        tick();
        as_ = 1'b1;

        // Flush blocks new accesses in IDLE
        tick();
        flush = 1'b1; as_ = 1'b0; addr = SPM_ADDR; rw = READ; spm_rd_data = 32'h1111_2222;
        @(negedge clk);
        chk("flush_spm_as", 64'(spm_as_), 64'd1);
        chk("flush_rd", 64'(rd_data), 64'd0);
        tick();
        addr = EXT_A;
        @(negedge clk);
        chk("flush_ext_busy", 64'(busy), 64'd0);
        tick();
        chk("flush_no_req", 64'(bus_req_), 64'd1);
        flush = 1'b0; as_ = 1'b1;

        // Reset while in ACCESS
        tick();
        gnt_wait = 0; rdy_never = 1'b1;
        addr = EXT_B; as_ = 1'b0; rw = READ;
        tick();
        tick();
        chk("rst_in_access", 64'(bus_as_), 64'd0);
        reset = 1'b1; as_ = 1'b1;
        tick();
        check_idle_outputs("rst_mid");
        reset = 1'b0; rdy_never = 1'b0;

        // Normal operation resumes after the mid-transaction reset
        tick();
        gnt_wait = 0; rdy_wait = 0; slave_data = 32'h0F0F_5A5A;
        addr = EXT_A; as_ = 1'b0; rw = READ;
        exp_q.push_back(32'h0F0F_5A5A);
        wait_done("post_rst", 20, cyc, as_lows, errs);
        chk("post_rst_cycles", 64'(cyc), 64'd2);
        sb_check("post_rst");
        tick();
        as_ = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
